// File: rtl/ac_eco_sequencer.sv
// ac_eco_sequencer: air-conditioner enable sequencer for the smart-home controller.
// Merges the user AC request, the eco-mode flag and the window/door contacts. It allows
// a grace period for a brief opening before cutting the AC, and it enforces a minimum
// compressor off-time before any restart.
//
// Ports:
//   clk_i               system clock
//   rst_n_i             asynchronous active-low reset
//   ac_request_i        user requests AC on (level)
//   eco_mode_valid_i    eco mode active
//   WINDOW_STATUS_i     per-window contact, 1 = open
//   DOOR_STATUS_i       per-door contact, 1 = open
//   ac_enable_o         relay drive (registered)
//   close_ac_o          1 while the AC is held off by eco mode (registered)
//   state_o             current FSM state encoding
//   eco_shutdown_cnt_o  saturating count of eco-forced shutdowns

`ifndef HOME_WINDOW_COUNT
`define HOME_WINDOW_COUNT 4
`endif
`ifndef HOME_DOOR_COUNT
`define HOME_DOOR_COUNT 2
`endif

module ac_eco_sequencer #(
  parameter int unsigned WIN_N          = `HOME_WINDOW_COUNT,
  parameter int unsigned DOOR_N         = `HOME_DOOR_COUNT,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned GRACE_CYCLES   = 1000,
  parameter int unsigned MIN_OFF_CYCLES = 5000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ac_request_i,
  input  logic              eco_mode_valid_i,
  input  logic [WIN_N-1:0]  WINDOW_STATUS_i,
  input  logic [DOOR_N-1:0] DOOR_STATUS_i,
  output logic              ac_enable_o,
  output logic              close_ac_o,
  output logic [2:0]        state_o,
  output logic [7:0]        eco_shutdown_cnt_o
);

  localparam int unsigned ST_W    = 3;
  localparam int unsigned SHUT_W  = 8;

  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_RUN      = 3'd1;
  localparam logic [ST_W-1:0] ST_GRACE    = 3'd2;
  localparam logic [ST_W-1:0] ST_ECO_OFF  = 3'd3;
  localparam logic [ST_W-1:0] ST_HOLD_OFF = 3'd4;

  localparam logic [CNT_W-1:0]  GRACE_LOAD   = CNT_W'(GRACE_CYCLES);
  localparam logic [CNT_W-1:0]  MIN_OFF_LOAD = CNT_W'(MIN_OFF_CYCLES);
  localparam logic [SHUT_W-1:0] SHUT_MAX     = {SHUT_W{1'b1}};

  logic [ST_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [SHUT_W-1:0] shut_cnt_q, shut_cnt_d;
  logic              ac_enable_q, ac_enable_d;
  logic              close_ac_q, close_ac_d;

  logic opening;
  logic timer_zero;

  // An opening only matters while eco mode is active.
  assign opening    = eco_mode_valid_i & ((|WINDOW_STATUS_i) | (|DOOR_STATUS_i));
  assign timer_zero = (timer_q == '0);

  // State, timer, counter and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      shut_cnt_q  <= '0;
      ac_enable_q <= 1'b0;
      close_ac_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      shut_cnt_q  <= shut_cnt_d;
      ac_enable_q <= ac_enable_d;
      close_ac_q  <= close_ac_d;
    end
  end

  // Next-state logic; the single timer serves both grace and off-time counting.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    shut_cnt_d = shut_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ac_request_i) begin
          if (opening) begin
            state_d = ST_ECO_OFF;
            timer_d = MIN_OFF_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!ac_request_i) begin
          state_d = ST_HOLD_OFF;
          timer_d = MIN_OFF_LOAD;
        end else if (opening) begin
          state_d = ST_GRACE;
          timer_d = GRACE_LOAD;
        end
      end
      ST_GRACE: begin
        if (!ac_request_i) begin
          state_d = ST_HOLD_OFF;
          timer_d = MIN_OFF_LOAD;
        end else if (!opening) begin
          state_d = ST_RUN;
        end else if (timer_zero) begin
          state_d = ST_ECO_OFF;
          timer_d = MIN_OFF_LOAD;
          if (shut_cnt_q != SHUT_MAX) begin
            shut_cnt_d = shut_cnt_q + SHUT_W'(1);
          end
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_ECO_OFF: begin
        // Off-time keeps running into HOLD_OFF so the compressor rest is not restarted.
        if (!timer_zero) begin
          timer_d = timer_q - CNT_W'(1);
        end
        if (!ac_request_i) begin
          state_d = ST_HOLD_OFF;
        end else if (!opening && timer_zero) begin
          state_d = ST_RUN;
        end
      end
      ST_HOLD_OFF: begin
        if (timer_zero) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track state_q.
  always_comb begin
    ac_enable_d = 1'b0;
    close_ac_d  = 1'b0;
    case (state_d)
      ST_RUN,
      ST_GRACE:   ac_enable_d = 1'b1;
      ST_ECO_OFF: close_ac_d  = 1'b1;
      default: begin
        ac_enable_d = 1'b0;
        close_ac_d  = 1'b0;
      end
    endcase
  end

  assign ac_enable_o        = ac_enable_q;
  assign close_ac_o         = close_ac_q;
  assign state_o            = state_q;
  assign eco_shutdown_cnt_o = shut_cnt_q;

endmodule

// File: tb/tb_ac_eco_sequencer.sv
// tb_ac_eco_sequencer: self-checking bench for ac_eco_sequencer. A deadline-based
// reference model (absolute step numbers rather than down-counters) predicts the
// published state, outputs and shutdown count.
module tb_ac_eco_sequencer;

  localparam int unsigned WIN_N   = 4;
  localparam int unsigned DOOR_N  = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned GRACE   = 4;
  localparam int unsigned MIN_OFF = 8;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              ac_request_i;
  logic              eco_mode_valid_i;
  logic [WIN_N-1:0]  win;
  logic [DOOR_N-1:0] door;
  logic              ac_enable_o;
  logic              close_ac_o;
  logic [2:0]        state_o;
  logic [7:0]        eco_shutdown_cnt_o;

  int checks = 0;
  int errors = 0;

  ac_eco_sequencer #(
    .WIN_N(WIN_N), .DOOR_N(DOOR_N), .CNT_W(CNT_W),
    .GRACE_CYCLES(GRACE), .MIN_OFF_CYCLES(MIN_OFF)
  ) dut (
    .clk_i              (clk_i),
    .rst_n_i            (rst_n_i),
    .ac_request_i       (ac_request_i),
    .eco_mode_valid_i   (eco_mode_valid_i),
    .WINDOW_STATUS_i    (win),
    .DOOR_STATUS_i      (door),
    .ac_enable_o        (ac_enable_o),
    .close_ac_o         (close_ac_o),
    .state_o            (state_o),
    .eco_shutdown_cnt_o (eco_shutdown_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  // Phase values are the published state_o codes. Timers are expressed as the
  // absolute step number at which the wait is over.
  int m_phase;
  int m_cnt;
  int m_step;
  int m_grace_done;
  int m_off_done;

  function automatic bit m_en();
    return (m_phase == 1) || (m_phase == 2);
  endfunction

  function automatic bit m_close();
    return m_phase == 3;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    m_step  = 0;
    m_grace_done = 0;
    m_off_done   = 0;
  endtask

  task automatic model_step();
    bit req;
    bit open;
    m_step++;
    req  = ac_request_i;
    open = eco_mode_valid_i && ((win != '0) || (door != '0));
    case (m_phase)
      0: if (req) begin
           if (open) begin m_phase = 3; m_off_done = m_step + MIN_OFF + 1; end
           else m_phase = 1;
         end
      1: if (!req) begin m_phase = 4; m_off_done = m_step + MIN_OFF + 1; end
         else if (open) begin m_phase = 2; m_grace_done = m_step + GRACE + 1; end
      2: if (!req) begin m_phase = 4; m_off_done = m_step + MIN_OFF + 1; end
         else if (!open) m_phase = 1;
         else if (m_step >= m_grace_done) begin
           m_phase = 3;
           m_off_done = m_step + MIN_OFF + 1;
           m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
         end
      3: if (!req) m_phase = 4;
         else if (!open && m_step >= m_off_done) m_phase = 1;
      4: if (m_step >= m_off_done) m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  // Advance one clock: model consumes the inputs the DUT samples, then settle.
  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_inputs(input bit req, input bit eco,
                            input logic [WIN_N-1:0] w, input logic [DOOR_N-1:0] d);
    ac_request_i     = req;
    eco_mode_valid_i = eco;
    win              = w;
    door             = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_inputs(1'b0, 1'b0, '0, '0);
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (state_o !== 3'd0 || ac_enable_o !== 1'b0 || close_ac_o !== 1'b0 || eco_shutdown_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL reset: state=%0d en=%b close=%b cnt=%0d, want 0/0/0/0",
               state_o, ac_enable_o, close_ac_o, eco_shutdown_cnt_o);
    end
    rst_n_i = 1'b1;
    model_reset();
    tick();
    checks++;
    if (state_o !== 3'd0 || ac_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: state=%0d en=%b, want 0/0", state_o, ac_enable_o);
    end
  endtask

  task automatic test_start();
    set_inputs(1'b1, 1'b1, '0, '0);
    tick();
    checks++;
    if (ac_enable_o !== 1'b1 || state_o !== 3'd1 || close_ac_o !== 1'b0) begin
      errors++;
      $display("FAIL start_latency: en=%b state=%0d close=%b, want 1/1/0",
               ac_enable_o, state_o, close_ac_o);
    end
  endtask

  task automatic test_brief_opening();
    win = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (state_o !== 3'd2 || ac_enable_o !== 1'b1) begin
        errors++;
        $display("FAIL grace_hold[%0d]: state=%0d en=%b, want 2/1", i, state_o, ac_enable_o);
      end
    end
    win = '0;
    tick();
    checks++;
    if (state_o !== 3'd1 || ac_enable_o !== 1'b1 || eco_shutdown_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL grace_return: state=%0d en=%b cnt=%0d, want 1/1/0",
               state_o, ac_enable_o, eco_shutdown_cnt_o);
    end
  endtask

  task automatic test_eco_shutdown();
    int n;
    int m;
    door = 2'b01;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n++;
      if (ac_enable_o === 1'b0) break;
    end
    checks++;
    if (n != int'(GRACE) + 2 || close_ac_o !== 1'b1 || eco_shutdown_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL eco_cut: cycles=%0d close=%b cnt=%0d, want %0d/1/1",
               n, close_ac_o, eco_shutdown_cnt_o, GRACE + 2);
    end
    tick();
    door = '0;
    m = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      m++;
      if (ac_enable_o === 1'b1) break;
    end
    checks++;
    if (ac_enable_o !== 1'b1 || m != int'(MIN_OFF) || state_o !== 3'd1) begin
      errors++;
      $display("FAIL eco_restart: cycles=%0d en=%b state=%0d, want %0d/1/1",
               m, ac_enable_o, state_o, MIN_OFF);
    end
    checks++;
    if (1 + n - int'(GRACE) - 2 + m < int'(MIN_OFF) + 1 - 1 || m + 1 < int'(MIN_OFF) + 1) begin
      errors++;
      $display("FAIL eco_min_off: low_cycles=%0d, want >= %0d", m + 1, MIN_OFF + 1);
    end
  endtask

  task automatic test_eco_disabled();
    set_inputs(1'b1, 1'b0, '1, '0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state_o !== 3'd1 || ac_enable_o !== 1'b1 || close_ac_o !== 1'b0) begin
        errors++;
        $display("FAIL eco_off_ignores_windows[%0d]: state=%0d en=%b close=%b, want 1/1/0",
                 i, state_o, ac_enable_o, close_ac_o);
      end
    end
    set_inputs(1'b1, 1'b1, '0, '0);
  endtask

  task automatic test_hold_off();
    int low;
    bit saw_idle;
    ac_request_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 3'd4 || ac_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_enter: state=%0d en=%b, want 4/0", state_o, ac_enable_o);
    end
    ac_request_i = 1'b1;
    low = 1;
    saw_idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (state_o === 3'd0) saw_idle = 1'b1;
      if (ac_enable_o === 1'b1) break;
      low++;
    end
    checks++;
    if (ac_enable_o !== 1'b1 || low < int'(MIN_OFF) + 1 || !saw_idle || state_o !== 3'(m_phase)) begin
      errors++;
      $display("FAIL hold_restart: en=%b low=%0d idle_seen=%b state=%0d, want 1/>=%0d/1/%0d",
               ac_enable_o, low, saw_idle, state_o, MIN_OFF + 1, m_phase);
    end
  endtask

  task automatic test_async_reset();
    win = 4'b0010;
    tick();
    tick();
    checks++;
    if (state_o !== 3'd2) begin
      errors++;
      $display("FAIL pre_reset_grace: state=%0d, want 2", state_o);
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || ac_enable_o !== 1'b0 || close_ac_o !== 1'b0 || eco_shutdown_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: state=%0d en=%b close=%b cnt=%0d, want 0/0/0/0",
               state_o, ac_enable_o, close_ac_o, eco_shutdown_cnt_o);
    end
    set_inputs(1'b0, 1'b1, '0, '0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_saturate();
    set_inputs(1'b1, 1'b1, '0, '0);
    for (int k = 0; k < 256; k++) begin
      door = '0;
      for (int i = 0; i < 100 && ac_enable_o !== 1'b1; i++) tick();
      door = 2'b10;
      for (int i = 0; i < 20 && close_ac_o !== 1'b1; i++) tick();
      if (k == 0 || k == 254 || k == 255) begin
        checks++;
        if (eco_shutdown_cnt_o !== 8'(m_cnt) || close_ac_o !== 1'b1) begin
          errors++;
          $display("FAIL sat_step[%0d]: cnt=%0d close=%b, want %0d/1",
                   k, eco_shutdown_cnt_o, close_ac_o, m_cnt);
        end
      end
    end
    checks++;
    if (eco_shutdown_cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL saturate: cnt=%0d, want 255", eco_shutdown_cnt_o);
    end
    door = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) ac_request_i = ~ac_request_i;
      if ($urandom_range(0, 59) == 0) eco_mode_valid_i = ~eco_mode_valid_i;
      if ($urandom_range(0, 9) == 0) begin
        win  = ($urandom_range(0, 2) == 0) ? WIN_N'($urandom) : '0;
        door = ($urandom_range(0, 3) == 0) ? DOOR_N'($urandom) : '0;
      end
      tick();
      checks++;
      if (state_o !== 3'(m_phase) || ac_enable_o !== m_en() || close_ac_o !== m_close() ||
          eco_shutdown_cnt_o !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL random[%0d]: state=%0d/%0d en=%b/%b close=%b/%b cnt=%0d/%0d (got/want)",
                 c, state_o, m_phase, ac_enable_o, m_en(), close_ac_o, m_close(),
                 eco_shutdown_cnt_o, m_cnt);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_brief_opening();
    test_eco_shutdown();
    test_eco_disabled();
    test_hold_off();
    test_async_reset();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
